// File: rtl/pipe_stage_hs_pkg.sv
// Shared encodings for the handshake pipeline stage: occupancy/state values and the NOP bubble.
package pipe_stage_hs_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } occ_state_e;

    // RISC-V "addi x0, x0, 0", the bubble for instruction-carrying stages.
    localparam logic [31:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/pipe_stage_hs_if.sv
// Valid/ready payload channel between pipeline stages.
interface pipe_stage_hs_if #(
    parameter int DW = 32
);
    // A beat moves on a clock edge where valid & ready are both 1. The master keeps
    // valid and data stable until that edge; ready may change freely in any cycle.
    logic          valid;
    logic          ready;
    logic [DW-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/pipe_stage_ctrl.sv
// Occupancy FSM for pipe_stage_hs: tracks held entries and emits per-cycle register strobes.
module pipe_stage_ctrl
    import pipe_stage_hs_pkg::*;
#(
    parameter bit SKID = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    input  logic       in_valid,
    input  logic       out_ready,
    output logic       in_ready,
    output logic       out_valid,
    output logic       load_main,
    output logic       load_skid,
    output logic       sel_skid,
    output logic       clr_main,
    output logic [1:0] occ
);

    occ_state_e state;
    logic       in_ready_r;
    logic       in_xfer;
    logic       out_xfer;

    assign out_valid = (state != ST_EMPTY);
    assign occ       = state;

    // With a skid entry the upstream ready is a flop; without it ready looks through to out_ready.
    generate
        if (SKID) begin : g_ready_reg
            assign in_ready = in_ready_r & ~flush;
        end else begin : g_ready_comb
            assign in_ready = ~flush & (~out_valid | out_ready);
        end
    endgenerate

    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;

    assign load_main = in_xfer & ((state == ST_EMPTY) | out_xfer);
    assign load_skid = in_xfer & (state == ST_ONE) & ~out_xfer;
    assign sel_skid  = (state == ST_TWO) & out_xfer;
    assign clr_main  = out_xfer & ~in_xfer & (state == ST_ONE);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state      <= ST_EMPTY;
            in_ready_r <= 1'b1;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (in_xfer) state <= ST_ONE;
                end
                ST_ONE: begin
                    if (in_xfer && !out_xfer) begin
                        state      <= ST_TWO;
                        in_ready_r <= 1'b0;
                    end else if (!in_xfer && out_xfer) begin
                        state <= ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (out_xfer) begin
                        state      <= ST_ONE;
                        in_ready_r <= 1'b1;
                    end
                end
                default: begin
                    state      <= ST_EMPTY;
                    in_ready_r <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/pipe_stage_hs.sv
// Pipeline-stage register with valid/ready handshake, optional skid entry and a bubble payload.
module pipe_stage_hs
    import pipe_stage_hs_pkg::*;
#(
    parameter int            DW         = 32,
    parameter logic [DW-1:0] BUBBLE_VAL = {DW{1'b0}},
    parameter bit            SKID       = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    pipe_stage_hs_if.slave          in_if,
    pipe_stage_hs_if.master         out_if,
    output logic [1:0]              occ
);

    logic          in_ready;
    logic          out_valid;
    logic          load_main;
    logic          load_skid;
    logic          sel_skid;
    logic          clr_main;
    logic [DW-1:0] main_q;
    logic [DW-1:0] skid_q;

    pipe_stage_ctrl #(.SKID(SKID)) u_ctrl (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_if.valid),
        .out_ready (out_if.ready),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .load_main (load_main),
        .load_skid (load_skid),
        .sel_skid  (sel_skid),
        .clr_main  (clr_main),
        .occ       (occ)
    );

    assign in_if.ready  = in_ready;
    assign out_if.valid = out_valid;
    assign out_if.data  = main_q;

    // Skid promotion is checked before load_main; the FSM never raises both at once.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            main_q <= BUBBLE_VAL;
        end else if (sel_skid) begin
            main_q <= skid_q;
        end else if (load_main) begin
            main_q <= in_if.data;
        end else if (clr_main) begin
            main_q <= BUBBLE_VAL;
        end
    end

    generate
        if (SKID) begin : g_skid
            always_ff @(posedge clk) begin
                if (rst || flush) begin
                    skid_q <= BUBBLE_VAL;
                end else if (load_skid) begin
                    skid_q <= in_if.data;
                end
            end
        end else begin : g_no_skid
            assign skid_q = BUBBLE_VAL;
        end
    endgenerate

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Directed + random check of pipe_stage_hs with SKID=1 (dut_s) and SKID=0 (dut_n) side by side.
module tb_pipe_stage_hs;
    import pipe_stage_hs_pkg::*;

    localparam int            DW = 32;
    localparam logic [DW-1:0] BV = NOP;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush_s;
    logic       flush_n;
    logic [1:0] occ_s;
    logic [1:0] occ_n;

    pipe_stage_hs_if #(.DW(DW)) s_in ();
    pipe_stage_hs_if #(.DW(DW)) s_out ();
    pipe_stage_hs_if #(.DW(DW)) n_in ();
    pipe_stage_hs_if #(.DW(DW)) n_out ();

    pipe_stage_hs #(.DW(DW), .BUBBLE_VAL(BV), .SKID(1'b1)) dut_s (
        .clk    (clk),
        .rst    (rst),
        .flush  (flush_s),
        .in_if  (s_in),
        .out_if (s_out),
        .occ    (occ_s)
    );

    pipe_stage_hs #(.DW(DW), .BUBBLE_VAL(BV), .SKID(1'b0)) dut_n (
        .clk    (clk),
        .rst    (rst),
        .flush  (flush_n),
        .in_if  (n_in),
        .out_if (n_out),
        .occ    (occ_n)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] exp_s[$];
    logic [DW-1:0] exp_n[$];
    int n_asserts = 0;
    int n_fail    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Transfers are sampled mid-cycle, where the values the next edge will see are settled.
    task automatic monitor();
        logic [DW-1:0] e;
        if (rst) begin
            exp_s.delete();
            exp_n.delete();
        end else begin
            if (s_out.valid && s_out.ready) begin
                chk("s_sb_nonempty", 32'(exp_s.size() != 0), 32'd1);
                if (exp_s.size() != 0) begin
                    e = exp_s.pop_front();
                    chk("s_out_data_sb", s_out.data, e);
                end
            end
            if (flush_s) exp_s.delete();
            else if (s_in.valid && s_in.ready) exp_s.push_back(s_in.data);

            if (n_out.valid && n_out.ready) begin
                chk("n_sb_nonempty", 32'(exp_n.size() != 0), 32'd1);
                if (exp_n.size() != 0) begin
                    e = exp_n.pop_front();
                    chk("n_out_data_sb", n_out.data, e);
                end
            end
            if (flush_n) exp_n.delete();
            else if (n_in.valid && n_in.ready) exp_n.push_back(n_in.data);
        end
    endtask

    // One clock: sample at negedge, then land 1 time unit after the next posedge.
    task automatic cycle();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_s(input string tag, input logic [1:0] o, input logic v, input logic [DW-1:0] d);
        chk({tag, "_s_occ"}, 32'(occ_s), 32'(o));
        chk({tag, "_s_valid"}, 32'(s_out.valid), 32'(v));
        chk({tag, "_s_data"}, s_out.data, d);
    endtask

    task automatic chk_n(input string tag, input logic [1:0] o, input logic v, input logic [DW-1:0] d);
        chk({tag, "_n_occ"}, 32'(occ_n), 32'(o));
        chk({tag, "_n_valid"}, 32'(n_out.valid), 32'(v));
        chk({tag, "_n_data"}, n_out.data, d);
    endtask

    initial begin
        rst = 1'b1; flush_s = 1'b0; flush_n = 1'b0;
        s_in.valid = 1'b0; s_in.data = '0; s_out.ready = 1'b0;
        n_in.valid = 1'b0; n_in.data = '0; n_out.ready = 1'b0;

        // Reset
        cycle();
        cycle();
        chk_s("reset", 2'd0, 1'b0, BV);
        chk_n("reset", 2'd0, 1'b0, BV);
        rst = 1'b0;
        #1;
        chk("reset_s_in_ready", 32'(s_in.ready), 32'd1);
        chk("reset_n_in_ready", 32'(n_in.ready), 32'd1);

        // Streaming on SKID=1
        s_out.ready = 1'b1;
        for (int d = 1; d <= 4; d++) begin
            s_in.valid = 1'b1;
            s_in.data  = 32'(d);
            cycle();
            chk_s("stream", 2'd1, 1'b1, 32'(d));
        end
        s_in.valid = 1'b0;
        cycle();
        chk_s("stream_end", 2'd0, 1'b0, BV);

        // Back-pressure on SKID=1
        s_out.ready = 1'b0;
        s_in.valid  = 1'b1; s_in.data = 32'hA;
        cycle();
        chk_s("bp_a", 2'd1, 1'b1, 32'hA);
        s_in.data = 32'hB;
        cycle();
        chk_s("bp_b", 2'd2, 1'b1, 32'hA);
        chk("bp_in_ready_low", 32'(s_in.ready), 32'd0);
        s_in.data = 32'hEE;
        cycle();
        chk_s("bp_hold", 2'd2, 1'b1, 32'hA);
        s_in.valid = 1'b0; s_out.ready = 1'b1;
        cycle();
        chk_s("bp_drain1", 2'd1, 1'b1, 32'hB);
        cycle();
        chk_s("bp_drain2", 2'd0, 1'b0, BV);
        chk("bp_in_ready_high", 32'(s_in.ready), 32'd1);

        // Flush with two entries held on SKID=1
        s_out.ready = 1'b0;
        s_in.valid = 1'b1; s_in.data = 32'hA;
        cycle();
        s_in.data = 32'hB;
        cycle();
        chk_s("fl_full", 2'd2, 1'b1, 32'hA);
        flush_s = 1'b1; s_in.data = 32'hC;
        #1;
        chk("fl_in_ready", 32'(s_in.ready), 32'd0);
        cycle();
        flush_s = 1'b0; s_in.valid = 1'b0;
        chk_s("fl_after", 2'd0, 1'b0, BV);
        s_out.ready = 1'b1;
        cycle();
        cycle();
        chk_s("fl_no_c", 2'd0, 1'b0, BV);

        // Reset with one entry held on SKID=1
        s_out.ready = 1'b0;
        s_in.valid = 1'b1; s_in.data = 32'hD;
        cycle();
        chk_s("rs_one", 2'd1, 1'b1, 32'hD);
        rst = 1'b1; s_in.data = 32'hE;
        cycle();
        chk_s("rs_after", 2'd0, 1'b0, BV);
        rst = 1'b0; s_in.valid = 1'b0; s_out.ready = 1'b1;
        cycle();
        cycle();
        chk_s("rs_no_out", 2'd0, 1'b0, BV);

        // SKID=0: combinational ready pass-through
        n_out.ready = 1'b0;
        n_in.valid = 1'b1; n_in.data = 32'h55;
        cycle();
        chk_n("n0_hold", 2'd1, 1'b1, 32'h55);
        n_in.valid = 1'b0;
        #1;
        chk("n0_in_ready_low", 32'(n_in.ready), 32'd0);
        n_out.ready = 1'b1; n_in.valid = 1'b1; n_in.data = 32'h66;
        #1;
        chk("n0_in_ready_high", 32'(n_in.ready), 32'd1);
        cycle();
        chk_n("n0_new", 2'd1, 1'b1, 32'h66);
        for (int d = 7; d <= 9; d++) begin
            n_in.data = 32'(d);
            cycle();
            chk_n("n0_stream", 2'd1, 1'b1, 32'(d));
        end
        flush_n = 1'b1;
        #1;
        chk("n0_flush_ready", 32'(n_in.ready), 32'd0);
        cycle();
        flush_n = 1'b0; n_in.valid = 1'b0;
        chk_n("n0_flushed", 2'd0, 1'b0, BV);

        // Random traffic on both, occupancy tracked against the scoreboard depth
        repeat (300) begin
            s_in.valid  = 1'($urandom_range(0, 1));
            s_in.data   = $urandom;
            s_out.ready = ($urandom_range(0, 3) != 0);
            n_in.valid  = 1'($urandom_range(0, 1));
            n_in.data   = $urandom;
            n_out.ready = ($urandom_range(0, 3) != 0);
            cycle();
            chk("rnd_s_occ", 32'(occ_s), 32'(exp_s.size()));
            chk("rnd_n_occ", 32'(occ_n), 32'(exp_n.size()));
        end

        s_in.valid = 1'b0; s_out.ready = 1'b1;
        n_in.valid = 1'b0; n_out.ready = 1'b1;
        repeat (4) cycle();
        chk("drain_s_empty", 32'(exp_s.size()), 32'd0);
        chk("drain_n_empty", 32'(exp_n.size()), 32'd0);
        chk_s("drain", 2'd0, 1'b0, BV);
        chk_n("drain", 2'd0, 1'b0, BV);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
